// File: rtl/frame_collector_pkg.sv
// rtl/frame_collector_pkg.sv - frame geometry, FSM states and FIFO beat type for frame_collector
package frame_collector_pkg;

    localparam int IMG_W      = 636;
    localparam int IMG_H      = 480;
    localparam int LANES      = 36;
    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 8 * LANES;
    localparam int BPR        = (IMG_W + LANES - 1) / LANES;
    localparam int LAST_LANES = IMG_W - (BPR - 1) * LANES;
    localparam int TOTAL      = BPR * IMG_H;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [LANES-1:0]  mask;
    } beat_t;

    // Lane 0 sits in the top byte and is enabled by the top mask bit.
    function automatic logic [31:0] masked_sum(input logic [DATA_W-1:0] data,
                                               input logic [LANES-1:0]  mask);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < LANES; i++) begin
            if (mask[LANES-1-i]) begin
                s = s + 32'(data[DATA_W-1-8*i -: 8]);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/frame_collector_if.sv
// rtl/frame_collector_if.sv - pixel beat input and frame-memory write port bundle
interface frame_collector_if;
    import frame_collector_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_pixels;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [LANES-1:0]  wr_mask;

    modport slave (
        input  in_valid, in_pixels, wr_ready,
        output wr_valid, wr_addr, wr_data, wr_mask
    );

    modport master (
        output in_valid, in_pixels, wr_ready,
        input  wr_valid, wr_addr, wr_data, wr_mask
    );

endinterface

// File: rtl/frame_collector_fifo.sv
// rtl/frame_collector_fifo.sv - synchronous beat FIFO; a push while full succeeds only alongside a pop
module collector_fifo
    import frame_collector_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  beat_t din,
    input  logic  pop,
    output beat_t dout,
    output logic  full,
    output logic  empty
);

    localparam int PW = $clog2(DEPTH);

    beat_t          mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/frame_collector.sv
// rtl/frame_collector.sv - tracks raster position of filter beats, buffers them to frame memory, checksums each frame
module frame_collector
    import frame_collector_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    frame_collector_if.slave    bus,
    output logic                frame_done,
    output logic [31:0]         checksum,
    output logic                overflow,
    output logic                protocol_err
);

    localparam int BW = $clog2(BPR);
    localparam int RW = $clog2(IMG_H);
    localparam logic [BW-1:0]    BEAT_LAST = BW'(BPR - 1);
    localparam logic [RW-1:0]    ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [LANES-1:0] LAST_MASK = {{LAST_LANES{1'b1}}, {(LANES-LAST_LANES){1'b0}}};

    state_t             state;
    logic [BW-1:0]      beat_cnt;
    logic [RW-1:0]      row_cnt;
    logic [ADDR_W-1:0]  addr_cnt;
    logic [31:0]        run_sum;

    logic               accept;
    logic               last_in_row;
    logic               last_beat;
    logic               pop;
    logic               full;
    logic               empty;
    beat_t              push_beat;
    beat_t              head;

    assign accept      = bus.in_valid && (state == IDLE || state == RUN);
    assign last_in_row = (beat_cnt == BEAT_LAST);
    assign last_beat   = last_in_row && (row_cnt == ROW_LAST);
    assign pop         = bus.wr_valid && bus.wr_ready;

    assign push_beat.addr = addr_cnt;
    assign push_beat.data = bus.in_pixels;
    assign push_beat.mask = last_in_row ? LAST_MASK : '1;

    collector_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .din   (push_beat),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.wr_valid = !empty;
    assign bus.wr_addr  = head.addr;
    assign bus.wr_data  = head.data;
    assign bus.wr_mask  = head.mask;

    // Dropped beats still advance counters and checksum so later addresses stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            row_cnt      <= '0;
            addr_cnt     <= '0;
            run_sum      <= '0;
            checksum     <= '0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (bus.in_valid && !accept) begin
                protocol_err <= 1'b1;
            end
            if (accept && full && !pop) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE, RUN: begin
                    if (accept) begin
                        run_sum  <= run_sum + masked_sum(push_beat.data, push_beat.mask);
                        addr_cnt <= addr_cnt + 1'b1;
                        if (last_in_row) begin
                            beat_cnt <= '0;
                            row_cnt  <= row_cnt + 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                        if (last_beat) begin
                            row_cnt  <= '0;
                            addr_cnt <= '0;
                            state    <= DRAIN;
                        end else begin
                            state    <= RUN;
                        end
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        frame_done <= 1'b1;
                        checksum   <= run_sum;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    run_sum <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_collector.sv
// tb/tb_frame_collector.sv - randomized self-checking bench for frame_collector against a beat-index model
module tb_frame_collector;
    import frame_collector_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_done;
    logic [31:0] checksum;
    logic        overflow;
    logic        protocol_err;

    always #5 clk = ~clk;

    frame_collector_if bus();

    frame_collector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .frame_done   (frame_done),
        .checksum     (checksum),
        .overflow     (overflow),
        .protocol_err (protocol_err)
    );

    // Model state: queue of pending writes, linear beat index within the frame.
    beat_t            mq[$];
    int               m_idx;
    bit               m_drain, m_done, m_ovf, m_perr;
    bit [31:0]        m_sum, m_cks;

    int               n_cmp, n_err;
    int               fd_cnt;
    int               wlog[$];
    logic [LANES-1:0] wmask[$];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] beat_sum(input logic [DATA_W-1:0] pix, input int nl);
        bit [31:0] s = 0;
        for (int i = 0; i < nl; i++) s += 32'(pix[DATA_W-1-8*i -: 8]);
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] rnd_pix();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[8*i +: 8] = 8'($urandom);
        return r;
    endfunction

    task automatic model_edge();
        int               pre_sz;
        bit               pre_drain, pre_done, pop, acc;
        int               nl;
        beat_t            b;
        logic [LANES-1:0] ones;
        ones      = '1;
        pre_sz    = mq.size();
        pre_drain = m_drain;
        pre_done  = m_done;
        pop       = (pre_sz > 0) && bus.wr_ready;
        acc       = bus.in_valid && !pre_drain && !pre_done;
        if (pop) mq.delete(0);
        if (acc) begin
            nl     = (m_idx % BPR == BPR - 1) ? LAST_LANES : LANES;
            b.addr = ADDR_W'(m_idx);
            b.data = bus.in_pixels;
            b.mask = ones << (LANES - nl);
            m_sum += beat_sum(bus.in_pixels, nl);
            if (pre_sz < FIFO_DEPTH || pop) mq.push_back(b);
            else m_ovf = 1;
            m_idx++;
            if (m_idx == TOTAL) begin
                m_idx   = 0;
                m_drain = 1;
            end
        end else if (bus.in_valid) begin
            m_perr = 1;
        end
        m_done = 0;
        if (pre_done) begin
            m_sum = 0;
        end else if (pre_drain && pre_sz == 0) begin
            m_drain = 0;
            m_done  = 1;
            m_cks   = m_sum;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_idx = 0; m_drain = 0; m_done = 0; m_ovf = 0; m_perr = 0;
            m_sum = 0; m_cks = 0;
        end else begin
            model_edge();
        end
    end

    task automatic compare_cycle();
        check("wr_valid", DATA_W'(bus.wr_valid), DATA_W'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("wr_addr", DATA_W'(bus.wr_addr), DATA_W'(mq[0].addr));
            check("wr_data", bus.wr_data, mq[0].data);
            check("wr_mask", DATA_W'(bus.wr_mask), DATA_W'(mq[0].mask));
        end
        check("frame_done", DATA_W'(frame_done), DATA_W'(m_done));
        check("checksum", DATA_W'(checksum), DATA_W'(m_cks));
        check("overflow", DATA_W'(overflow), DATA_W'(m_ovf));
        check("protocol_err", DATA_W'(protocol_err), DATA_W'(m_perr));
        if (rst_n && bus.wr_valid && bus.wr_ready) begin
            wlog.push_back(int'(bus.wr_addr));
            wmask.push_back(bus.wr_mask);
        end
        if (rst_n && frame_done) fd_cnt++;
    endtask

    initial forever begin
        @(negedge clk);
        compare_cycle();
    end

    task automatic step(input bit v, input logic [DATA_W-1:0] p, input bit r);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_pixels = p;
        bus.wr_ready  = r;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.wr_ready  = 1'b0;
        #12;
        rst_n = 1'b1;
        wlog.delete();
        wmask.delete();
        fd_cnt = 0;
    endtask

    task automatic wait_done(input bit slow);
        int start;
        int c;
        start = fd_cnt;
        c     = 0;
        while (fd_cnt == start && c < 3000) begin
            step(1'b0, '0, slow ? (c % 4 == 1) : 1'b1);
            c++;
        end
        step(1'b0, '0, 1'b1);
        check("frame_done_seen", DATA_W'(fd_cnt - start), DATA_W'(1));
    endtask

    function automatic int order_errors();
        int bad = 0;
        for (int i = 0; i < wlog.size(); i++) if (wlog[i] != i) bad++;
        return bad;
    endfunction

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pixels = '0;
        bus.wr_ready  = 1'b0;
        n_cmp = 0; n_err = 0; fd_cnt = 0;
        #2;
        check("reset_wr_valid", DATA_W'(bus.wr_valid), DATA_W'(0));
        check("reset_wr_addr", DATA_W'(bus.wr_addr), DATA_W'(0));

        // Full frame of 0x01 plus a stray beat while draining.
        do_reset();
        for (int i = 0; i < TOTAL; i++) step(1'b1, {LANES{8'h01}}, 1'b1);
        step(1'b1, {LANES{8'h01}}, 1'b1);
        wait_done(1'b0);
        check("t1_writes", DATA_W'(wlog.size()), DATA_W'(8640));
        check("t1_order", DATA_W'(order_errors()), DATA_W'(0));
        check("t1_mask17", DATA_W'(wmask[17]), DATA_W'(36'hFFFFFF000));
        check("t1_checksum", DATA_W'(checksum), DATA_W'(305280));
        check("t1_protocol_err", DATA_W'(protocol_err), DATA_W'(1));

        // Sparse beats with ready one cycle in four, random pixels.
        do_reset();
        for (int c = 0; c < 4 * TOTAL; c++) step(c % 4 == 0, rnd_pix(), c % 4 == 1);
        wait_done(1'b1);
        check("t2_writes", DATA_W'(wlog.size()), DATA_W'(8640));
        check("t2_order", DATA_W'(order_errors()), DATA_W'(0));
        check("t2_overflow", DATA_W'(overflow), DATA_W'(0));

        // Ten beats into a stalled FIFO, then an eleventh with ready.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, rnd_pix(), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, rnd_pix(), 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
        check("t3_overflow", DATA_W'(overflow), DATA_W'(1));
        check("t3_writes", DATA_W'(wlog.size()), DATA_W'(9));
        check("t3_addr7", DATA_W'(wlog[7]), DATA_W'(7));
        check("t3_addr_after_drop", DATA_W'(wlog[8]), DATA_W'(10));

        // Full FIFO with pop and push together keeps occupancy at 8.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, rnd_pix(), 1'b0);
        step(1'b1, rnd_pix(), 1'b1);
        step(1'b0, '0, 1'b0);
        check("t4_no_overflow", DATA_W'(overflow), DATA_W'(0));
        step(1'b1, rnd_pix(), 1'b0);
        step(1'b0, '0, 1'b0);
        check("t4_still_full", DATA_W'(overflow), DATA_W'(1));
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);
        check("t4_writes", DATA_W'(wlog.size()), DATA_W'(9));
        check("t4_addr8", DATA_W'(wlog[8]), DATA_W'(8));

        // Reset mid-frame, then a clean frame of 0x02.
        do_reset();
        for (int i = 0; i < 500; i++) step(1'b1, {LANES{8'h02}}, 1'b1);
        check("t6_no_early_done", DATA_W'(fd_cnt), DATA_W'(0));
        do_reset();
        for (int i = 0; i < TOTAL; i++) step(1'b1, {LANES{8'h02}}, 1'b1);
        wait_done(1'b0);
        check("t6_first_addr", DATA_W'(wlog[0]), DATA_W'(0));
        check("t6_writes", DATA_W'(wlog.size()), DATA_W'(8640));
        check("t6_checksum", DATA_W'(checksum), DATA_W'(610560));
        check("t6_overflow", DATA_W'(overflow), DATA_W'(0));
        check("t6_protocol_err", DATA_W'(protocol_err), DATA_W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
